// File: rtl/quad_decoder_multi.sv
// Multi-channel quadrature decoder: per-channel A/B synchroniser and deglitch filter,
// x1/x2/x4 decode into a wrapping or saturating position counter with preload and error flag.
module quad_decoder_multi #(
    parameter int CHANNELS    = 3,
    parameter int WIDTH       = 8,
    parameter int STEP        = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int SATURATE    = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          a,
    input  logic [CHANNELS-1:0]          b,
    input  logic [1:0]                   mode,
    input  logic [CHANNELS-1:0]          load,
    input  logic [WIDTH-1:0]             load_value,
    input  logic                         clear_err,
    output logic [CHANNELS*WIDTH-1:0]    value,
    output logic [CHANNELS-1:0]          step,
    output logic [CHANNELS-1:0]          dir,
    output logic [CHANNELS-1:0]          err
);

    localparam int SETTLE = SYNC_STAGES + FILTER_LEN;
    localparam int SW     = $clog2(SETTLE + 1);
    localparam int FW     = $clog2(FILTER_LEN + 1);
    localparam logic [SW-1:0]    SETTLE_END = SW'(SETTLE);
    localparam logic [FW-1:0]    FILT_LAST  = FW'(FILTER_LEN - 1);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MAX_W      = '1;

    logic [SW-1:0] settle_cnt_reg;
    logic          settling;
    logic          x4_mode;
    logic          x2_mode;

    // While settling, filtered and previous levels track the synchroniser so
    // pins already high at reset release do not look like edges.
    assign settling = (settle_cnt_reg != SETTLE_END);
    assign x4_mode  = mode[1];
    assign x2_mode  = (mode == 2'b01);

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt_reg <= '0;
        end else if (settling) begin
            settle_cnt_reg <= settle_cnt_reg + SW'(1);
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [1:0]       pin;      // bit 0 = A, bit 1 = B
        logic [1:0]       synced;
        logic [1:0]       filt;
        logic [1:0]       prev_reg;
        logic [WIDTH-1:0] value_reg;
        logic [WIDTH-1:0] value_next;
        logic             step_reg;
        logic             dir_reg;
        logic             err_reg;
        logic             a_chg;
        logic             b_chg;
        logic             illegal;
        logic             count_en;
        logic             up;

        assign pin = {b[gi], a[gi]};

        for (genvar gj = 0; gj < 2; gj++) begin : g_in
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [FW-1:0]          cnt_reg;
            logic                   filt_reg;

            assign synced[gj] = sync_reg[SYNC_STAGES-1];
            assign filt[gj]   = filt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_reg <= '0;
                    cnt_reg  <= '0;
                    filt_reg <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin[gj]};
                    if (settling) begin
                        filt_reg <= synced[gj];
                        cnt_reg  <= '0;
                    end else if (synced[gj] == filt_reg) begin
                        cnt_reg  <= '0;
                    end else if (cnt_reg == FILT_LAST) begin
                        filt_reg <= synced[gj];
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg  <= cnt_reg + FW'(1);
                    end
                end
            end
        end

        always_comb begin
            a_chg    = filt[0] ^ prev_reg[0];
            b_chg    = filt[1] ^ prev_reg[1];
            illegal  = a_chg & b_chg & ~settling;
            count_en = 1'b0;
            up       = 1'b0;
            if (!settling && a_chg && !b_chg) begin
                // x1 only counts A rising, i.e. new A level is 1
                count_en = x4_mode | x2_mode | filt[0];
                up       = filt[0] ^ filt[1];
            end else if (!settling && b_chg && !a_chg) begin
                count_en = x4_mode;
                up       = ~(filt[0] ^ filt[1]);
            end

            if (up) begin
                if (SATURATE != 0 && value_reg > MAX_W - STEP_W) begin
                    value_next = MAX_W;
                end else begin
                    value_next = value_reg + STEP_W;
                end
            end else begin
                if (SATURATE != 0 && value_reg < STEP_W) begin
                    value_next = '0;
                end else begin
                    value_next = value_reg - STEP_W;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                prev_reg  <= 2'b00;
                value_reg <= '0;
                step_reg  <= 1'b0;
                dir_reg   <= 1'b0;
                err_reg   <= 1'b0;
            end else begin
                prev_reg <= settling ? synced : filt;
                step_reg <= count_en & ~load[gi];
                if (load[gi]) begin
                    value_reg <= load_value;
                end else if (count_en) begin
                    value_reg <= value_next;
                    dir_reg   <= up;
                end
                if (illegal) begin
                    err_reg <= 1'b1;
                end else if (clear_err) begin
                    err_reg <= 1'b0;
                end
            end
        end

        assign value[gi*WIDTH +: WIDTH] = value_reg;
        assign step[gi]                 = step_reg;
        assign dir[gi]                  = dir_reg;
        assign err[gi]                  = err_reg;
    end

endmodule
